score_counter: RTL and testbench
================================

Name: score_counter

Overview:
- Producer of SCORE_COUNT for the master game state machine; consumer of its STATE output.
- Counts targets eaten during PLAY, saturates at the win score, and acknowledges each capture to the target generator so it relocates the target.
- Drives the Basys-3 four-digit seven-segment display with the current score.

Parameters:
WIN_SCORE, 10, saturation value; must match the master SM win compare (4'b1010)
REFRESH_BITS, 17, width of display refresh counter; one digit slot lasts 2^REFRESH_BITS clocks

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
MASTER_STATE  in  2  master SM state: 0 IDLE, 1 PLAY, 2 WIN, 3 unused
TARGET_REACHED  in  1  level, high while snake head address equals target address; may stay high many cycles
SCORE_COUNT  out  4  current score, 0..WIN_SCORE
TARGET_ACK  out  1  one-cycle pulse per counted capture
SEG_SELECT  out  4  digit anodes, active-low one-hot
HEX_OUT  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- One clock, CLK. RESET is synchronous, active-high, and takes priority over everything.
- Reset values:
  - SCORE_COUNT = 0
  - TARGET_ACK = 0
  - edge-detect register = 0
  - refresh counter = 0
  - digit index = 0
  - SEG_SELECT = 4'b1110
  - HEX_OUT = 8'hC0 (digit '0')
- Edge detect: a register holds the previous TARGET_REACHED. A capture event is TARGET_REACHED=1 with previous=0. A held level produces exactly one event.
- Score state per MASTER_STATE:
  - IDLE: SCORE_COUNT cleared to 0 next cycle. No events counted; TARGET_ACK held 0.
  - PLAY: on a capture event with SCORE_COUNT < WIN_SCORE, SCORE_COUNT increments and TARGET_ACK is 1. Both are registered, so they appear in the cycle after the rising edge is sampled. With SCORE_COUNT == WIN_SCORE the event is ignored, no ACK, and the count saturates.
  - WIN: SCORE_COUNT frozen, no ACK.
  - 3: treated as IDLE.
- TARGET_ACK is high for exactly one cycle per counted event and is never asserted in consecutive cycles.
- Edge-detect register updates in every state. A TARGET_REACHED that rises in IDLE and stays high into PLAY is not counted.
- Reset mid-PLAY: score returns to 0 on the next edge and any pending ACK is dropped.
- Display refresh:
  - The refresh counter free-runs. When it wraps from all-ones to 0, the digit index advances 0→1→2→3→0.
  - SEG_SELECT and HEX_OUT are registered from the index and score; one cycle of latency after the index changes.
  - Index 0 → SEG_SELECT 1110, units digit of SCORE_COUNT.
  - Index 1 → SEG_SELECT 1101, tens digit. A leading zero is blanked (HEX_OUT=8'hFF) when score < 10.
  - Indices 2,3 → SEG_SELECT 1011 / 0111, blank (8'hFF) unless the optional feature is enabled.
  - Decimal point is always off.
- Segment codes (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Units and tens come from a compare against 10 (score ≤ 10, so no divider). Values above 9 that reach the decoder display blank.

Optional Feature:
Macro SCORE_BEST_EN.
- Defined:
  - Adds a 4-bit best register, cleared only by RESET.
  - Each cycle, if SCORE_COUNT > best, best is updated to SCORE_COUNT on the next edge.
  - Digit index 2 shows the best units digit; index 3 shows the best tens digit, with leading-zero blanking.
  - The best register is not cleared by IDLE.
- Not defined: no best register; digits 2,3 always blank (8'hFF).

Test Plan:
- RESET, MASTER_STATE=PLAY, TARGET_REACHED pulses 1 cycle three times, 5 cycles apart → SCORE_COUNT 1,2,3, each change one cycle after the pulse is sampled; three single-cycle TARGET_ACKs.
- PLAY, TARGET_REACHED held high 50 cycles → SCORE_COUNT increments once, exactly one TARGET_ACK.
- PLAY, 12 separate capture pulses → SCORE_COUNT stops at 10, only 10 ACKs; then MASTER_STATE=WIN plus further pulses → SCORE_COUNT stays 10, no ACK.
- Score 7 in PLAY, MASTER_STATE→IDLE → SCORE_COUNT 0 next cycle; pulse in IDLE → no count, no ACK. Assert RESET mid-PLAY at score 4 → 0 next cycle.
- REFRESH_BITS=3, score 10 → SEG_SELECT cycles 1110,1101,1011,0111, each held 8 clocks; HEX_OUT C0, F9, FF, FF. Score 5 → F9 replaced by FF on the tens digit, units 92.
- SCORE_BEST_EN defined: reach 6, go IDLE, reach 3 → digit 2 shows 82 (6), digit 3 FF; RESET → best 0.

Source files
------------

// File: rtl/score_counter.sv
// score_counter: counts target captures while the master state machine is
// in PLAY, saturates at WIN_SCORE, acknowledges each counted capture to the
// target generator, and multiplexes the score onto the Basys-3 four-digit
// seven-segment display.
//
// Optional build macro SCORE_BEST_EN: keeps a best-score register, which is
// cleared only by RESET, and shows it on digits 2 (units) and 3 (tens).
// Without the macro, digits 2 and 3 are always blank.
module score_counter #(
    parameter int WIN_SCORE    = 10,
    parameter int REFRESH_BITS = 17
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MASTER_STATE,
    input  logic       TARGET_REACHED,
    output logic [3:0] SCORE_COUNT,
    output logic       TARGET_ACK,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_WIN    = 2'd2,
        ST_UNUSED = 2'd3
    } master_state_t;

    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    master_state_t             master_state;
    logic                      reached_prev;
    logic                      capture;
    logic [REFRESH_BITS-1:0]   refresh_cnt;
    logic [1:0]                digit_idx;
    logic [3:0]                next_seg;
    logic [7:0]                next_hex;
    logic [3:0]                best_score;

    assign master_state = master_state_t'(MASTER_STATE);

    // A capture is the rising edge of the level-type TARGET_REACHED.
    assign capture = TARGET_REACHED & ~reached_prev;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; anything above 9 is blank.
    function automatic logic [7:0] seg_code(input logic [3:0] value);
        case (value)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Scores never exceed 10, so a compare replaces a divide-by-ten.
    function automatic logic [7:0] units_hex(input logic [3:0] value);
        units_hex = (value >= 4'd10) ? seg_code(value - 4'd10) : seg_code(value);
    endfunction

    // Tens digit with leading-zero blanking.
    function automatic logic [7:0] tens_hex(input logic [3:0] value);
        tens_hex = (value >= 4'd10) ? seg_code(4'd1) : SEG_BLANK;
    endfunction

    // Edge-detect history; tracks TARGET_REACHED in every master state.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RESET) reached_prev <= 1'b0;
        else       reached_prev <= TARGET_REACHED;
    end

    // Score and acknowledge, governed by the master state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SCORE_COUNT <= 4'd0;
            TARGET_ACK  <= 1'b0;
        end else begin
            TARGET_ACK <= 1'b0;
            case (master_state)
                ST_PLAY: begin
                    if (capture && (SCORE_COUNT < WIN_VAL)) begin
                        SCORE_COUNT <= SCORE_COUNT + 4'd1;
                        TARGET_ACK  <= 1'b1;
                    end
                end
                ST_WIN:  SCORE_COUNT <= SCORE_COUNT;
                default: SCORE_COUNT <= 4'd0;
            endcase
        end
    end

`ifdef SCORE_BEST_EN
    // Best score seen since reset; IDLE does not clear it.
    always_ff @(posedge CLK) begin
        if (RESET)                          best_score <= 4'd0;
        else if (SCORE_COUNT > best_score)  best_score <= SCORE_COUNT;
    end
`else
    assign best_score = 4'd0;
`endif

    // Free-running refresh counter; digit index steps on each wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            if (&refresh_cnt) digit_idx <= digit_idx + 2'd1;
        end
    end

    // Anode and segment pattern for the currently selected digit.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output
        // unassigned, which would otherwise infer a latch.
        next_seg = 4'b1110;
        next_hex = SEG_BLANK;
        case (digit_idx)
            2'd0: begin
                next_seg = 4'b1110;
                next_hex = units_hex(SCORE_COUNT);
            end
            2'd1: begin
                next_seg = 4'b1101;
                next_hex = tens_hex(SCORE_COUNT);
            end
            2'd2: begin
                next_seg = 4'b1011;
`ifdef SCORE_BEST_EN
                next_hex = units_hex(best_score);
`else
                next_hex = SEG_BLANK;
`endif
            end
            default: begin
                next_seg = 4'b0111;
`ifdef SCORE_BEST_EN
                next_hex = tens_hex(best_score);
`else
                next_hex = SEG_BLANK;
`endif
            end
        endcase
    end

    // Register the display drive so the pads see glitch-free levels.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SEG_SELECT <= 4'b1110;
            HEX_OUT    <= 8'hC0;
        end else begin
            SEG_SELECT <= next_seg;
            HEX_OUT    <= next_hex;
        end
    end

`ifndef SCORE_BEST_EN
    // The best score is only displayed when the feature is built in.
    logic unused_best;
    assign unused_best = ^best_score;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Directed self-checking bench for score_counter, built with a short
// refresh period (REFRESH_BITS = 3, eight clocks per digit slot).
module tb_score_counter;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_PLAY = 2'd1;
    localparam logic [1:0] M_WIN  = 2'd2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] MASTER_STATE = 2'd0;
    logic       TARGET_REACHED = 1'b0;
    logic [3:0] SCORE_COUNT;
    logic       TARGET_ACK;
    logic [3:0] SEG_SELECT;
    logic [7:0] HEX_OUT;

    int vectors = 0;
    int miscompares = 0;
    int ack_count = 0;
    int b2b_violations = 0;
    logic last_ack = 1'b0;

    score_counter #(.WIN_SCORE(10), .REFRESH_BITS(3)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MASTER_STATE   (MASTER_STATE),
        .TARGET_REACHED (TARGET_REACHED),
        .SCORE_COUNT    (SCORE_COUNT),
        .TARGET_ACK     (TARGET_ACK),
        .SEG_SELECT     (SEG_SELECT),
        .HEX_OUT        (HEX_OUT)
    );

    always #5 CLK = ~CLK;

    // Count acknowledge pulses shortly after each edge, away from the
    // negedge where the tests read the count.
    always @(posedge CLK) begin
        #1;
        if (TARGET_ACK) ack_count++;
        if (TARGET_ACK && last_ack) b2b_violations++;
        last_ack = TARGET_ACK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        TARGET_REACHED = 1'b0;
        MASTER_STATE = M_IDLE;
        step(2);
        RESET = 1'b0;
    endtask

    // One-cycle high pulse followed by one low cycle.
    task automatic pulse();
        @(negedge CLK);
        TARGET_REACHED = 1'b1;
        @(negedge CLK);
        TARGET_REACHED = 1'b0;
    endtask

    task automatic play_from_zero(input int n);
        @(negedge CLK);
        MASTER_STATE = M_IDLE;
        @(negedge CLK);
        MASTER_STATE = M_PLAY;
        repeat (n) pulse();
    endtask

    task automatic check_score(input string name, input logic [3:0] exp);
        vectors++;
        if (SCORE_COUNT !== exp) begin
            miscompares++;
            $display("FAIL %s: SCORE_COUNT got %0d expected %0d", name, SCORE_COUNT, exp);
        end
    endtask

    task automatic check_acks(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: ack pulses got %0d expected %0d", name, got, exp);
        end
    endtask

    // Aligns to the first cycle of the digit-0 slot, then checks 32 cycles.
    task automatic check_display(input string name, input logic [7:0] h0,
                                 input logic [7:0] h1, input logic [7:0] h2,
                                 input logic [7:0] h3);
        logic [3:0] es [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] eh [4];
        logic [3:0] prev_seg;
        int n;
        bit found;
        eh[0] = h0; eh[1] = h1; eh[2] = h2; eh[3] = h3;
        found = 1'b0;
        n = 0;
        @(negedge CLK);
        prev_seg = SEG_SELECT;
        while (!found && n < 64) begin
            @(negedge CLK);
            if (SEG_SELECT === 4'b1110 && prev_seg !== 4'b1110) found = 1'b1;
            prev_seg = SEG_SELECT;
            n++;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s sync: digit-0 slot start not seen within 64 cycles, SEG_SELECT %b", name, SEG_SELECT);
            return;
        end
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge CLK);
            vectors++;
            if (SEG_SELECT !== es[k/8] || HEX_OUT !== eh[k/8]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: SEG_SELECT %b HEX_OUT %h expected %b %h",
                         name, k, SEG_SELECT, HEX_OUT, es[k/8], eh[k/8]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        MASTER_STATE = M_PLAY;
        TARGET_REACHED = 1'b1;
        step(2);
        vectors++;
        if (SCORE_COUNT !== 4'd0 || TARGET_ACK !== 1'b0 ||
            SEG_SELECT !== 4'b1110 || HEX_OUT !== 8'hC0) begin
            miscompares++;
            $display("FAIL reset: score %0d ack %b seg %b hex %h expected 0 0 1110 c0",
                     SCORE_COUNT, TARGET_ACK, SEG_SELECT, HEX_OUT);
        end
        RESET = 1'b0;
        TARGET_REACHED = 1'b0;
        MASTER_STATE = M_IDLE;
        step(1);
    endtask

    task automatic test_play_pulses();
        do_reset();
        MASTER_STATE = M_PLAY;
        step(2);
        check_score("play start", 4'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            TARGET_REACHED = 1'b1;
            @(negedge CLK);
            TARGET_REACHED = 1'b0;
            check_score("play pulse", 4'(i));
            vectors++;
            if (TARGET_ACK !== 1'b1) begin
                miscompares++;
                $display("FAIL play ack %0d: TARGET_ACK got %b expected 1", i, TARGET_ACK);
            end
            @(negedge CLK);
            vectors++;
            if (TARGET_ACK !== 1'b0) begin
                miscompares++;
                $display("FAIL play ack width %0d: TARGET_ACK got %b expected 0", i, TARGET_ACK);
            end
            step(3);
        end
    endtask

    task automatic test_held_level();
        int a0;
        a0 = ack_count;
        @(negedge CLK);
        TARGET_REACHED = 1'b1;
        step(50);
        TARGET_REACHED = 1'b0;
        step(2);
        check_score("held level", 4'd4);
        check_acks("held level", ack_count - a0, 1);
    endtask

    task automatic test_saturation_and_win();
        int a0;
        @(negedge CLK);
        MASTER_STATE = M_IDLE;
        @(negedge CLK);
        MASTER_STATE = M_PLAY;
        a0 = ack_count;
        repeat (12) pulse();
        step(2);
        check_score("saturate", 4'd10);
        check_acks("saturate", ack_count - a0, 10);
        @(negedge CLK);
        MASTER_STATE = M_WIN;
        a0 = ack_count;
        repeat (3) pulse();
        step(2);
        check_score("win frozen", 4'd10);
        check_acks("win frozen", ack_count - a0, 0);
    endtask

    task automatic test_display_score10();
`ifdef SCORE_BEST_EN
        check_display("display 10", 8'hC0, 8'hF9, 8'hC0, 8'hF9);
`else
        check_display("display 10", 8'hC0, 8'hF9, 8'hFF, 8'hFF);
`endif
    endtask

    task automatic test_idle_and_reset();
        int a0;
        play_from_zero(7);
        step(1);
        check_score("reach 7", 4'd7);
        @(negedge CLK);
        MASTER_STATE = M_IDLE;
        @(negedge CLK);
        check_score("idle clear", 4'd0);
        a0 = ack_count;
        pulse();
        step(2);
        check_score("idle pulse", 4'd0);
        check_acks("idle pulse", ack_count - a0, 0);
        // Rise while IDLE and stay high into PLAY: no capture.
        a0 = ack_count;
        @(negedge CLK);
        TARGET_REACHED = 1'b1;
        step(2);
        MASTER_STATE = M_PLAY;
        step(3);
        TARGET_REACHED = 1'b0;
        step(1);
        check_score("idle rise into play", 4'd0);
        check_acks("idle rise into play", ack_count - a0, 0);
        // Reset mid-PLAY at score 4 coinciding with a fresh capture.
        repeat (4) pulse();
        check_score("reach 4", 4'd4);
        @(negedge CLK);
        TARGET_REACHED = 1'b1;
        RESET = 1'b1;
        @(negedge CLK);
        check_score("mid-play reset", 4'd0);
        vectors++;
        if (TARGET_ACK !== 1'b0) begin
            miscompares++;
            $display("FAIL mid-play reset ack: TARGET_ACK got %b expected 0", TARGET_ACK);
        end
        RESET = 1'b0;
        TARGET_REACHED = 1'b0;
        step(2);
        check_score("after reset", 4'd0);
    endtask

    task automatic test_display_score5();
        do_reset();
        play_from_zero(5);
        @(negedge CLK);
        MASTER_STATE = M_WIN;
        step(1);
        check_score("reach 5", 4'd5);
`ifdef SCORE_BEST_EN
        check_display("display 5", 8'h92, 8'hFF, 8'h92, 8'hFF);
`else
        check_display("display 5", 8'h92, 8'hFF, 8'hFF, 8'hFF);
`endif
    endtask

    task automatic test_back_to_back();
        vectors++;
        if (b2b_violations !== 0) begin
            miscompares++;
            $display("FAIL ack back-to-back: consecutive-cycle acks %0d expected 0", b2b_violations);
        end
    endtask

`ifdef SCORE_BEST_EN
    task automatic test_best();
        do_reset();
        play_from_zero(6);
        play_from_zero(3);
        @(negedge CLK);
        MASTER_STATE = M_WIN;
        step(1);
        check_score("best run", 4'd3);
        check_display("best 6", 8'hB0, 8'hFF, 8'h82, 8'hFF);
        do_reset();
        check_display("best reset", 8'hC0, 8'hFF, 8'hC0, 8'hFF);
    endtask
`endif

    initial begin
        test_reset();
        test_play_pulses();
        test_held_level();
        test_saturation_and_win();
        test_display_score10();
        test_idle_and_reset();
        test_display_score5();
        test_back_to_back();
`ifdef SCORE_BEST_EN
        test_best();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
